axilite4_slave_mem: RTL and testbench

Parametrised AXI-Lite 4 slave backed by an on-chip 1R1W memory, generalising the fixed 32-bit-read / 128-bit-write slave port.
- Read and write channels run independent handshake FSMs.
- Out-of-range accesses are detected and flagged.
- Used as a scratchpad or register-bank target behind the project bus.

---
 rtl/axilite4_slave_mem_if.sv | 40 ++++
 rtl/axilite4_slave_mem.sv | 196 +++++++++++++++++++
 tb/tb_axilite4_slave_mem.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite4_slave_mem_if.sv
// AXI-Lite 4 bus bundle for axilite4_slave_mem: read address/data, write
// address/data/response channels with master and slave views.
interface axilite4_slave_mem_if #(
  parameter int ADDR_W  = 32,
  parameter int RDATA_W = 32,
  parameter int WDATA_W = 128
);
  logic [ADDR_W-1:0]    readAddr_addr;
  logic                 readAddr_valid;
  logic                 readAddr_ready;
  logic [RDATA_W-1:0]   readData_data;
  logic                 readData_valid;
  logic                 readData_ready;
  logic [ADDR_W-1:0]    writeAddr_addr;
  logic                 writeAddr_valid;
  logic                 writeAddr_ready;
  logic [WDATA_W-1:0]   writeData_data;
  logic [WDATA_W/8-1:0] writeData_strb;
  logic                 writeData_valid;
  logic                 writeData_ready;
  logic [31:0]          writeResp_msg;
  logic                 writeResp_valid;
  logic                 writeResp_ready;

  modport slave (
    input  readAddr_addr, readAddr_valid, output readAddr_ready,
    output readData_data, readData_valid, input  readData_ready,
    input  writeAddr_addr, writeAddr_valid, output writeAddr_ready,
    input  writeData_data, writeData_strb, writeData_valid, output writeData_ready,
    output writeResp_msg, writeResp_valid, input  writeResp_ready
  );

  modport master (
    output readAddr_addr, readAddr_valid, input  readAddr_ready,
    input  readData_data, readData_valid, output readData_ready,
    output writeAddr_addr, writeAddr_valid, input  writeAddr_ready,
    output writeData_data, writeData_strb, writeData_valid, input  writeData_ready,
    input  writeResp_msg, writeResp_valid, output writeResp_ready
  );
endinterface

// File: rtl/axilite4_slave_mem.sv
// AXI-Lite 4 slave over a 1R1W line memory with independent read/write FSMs.
// Define AXIL_SLV_MEM_OUTREG_EN to add a read output register (extra cycle).
module axilite4_slave_mem #(
  parameter int          ADDR_W    = 32,
  parameter int          RDATA_W   = 32,
  parameter int          WDATA_W   = 128,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic clock,
  input  logic reset,
  axilite4_slave_mem_if.slave bus
);

  localparam int STRB_W   = WDATA_W / 8;
  localparam int LINE_LSB = $clog2(STRB_W);
  localparam int DEPTH_W  = $clog2(DEPTH);
  localparam int RD_LSB   = $clog2(RDATA_W / 8);
  localparam int LANES    = WDATA_W / RDATA_W;
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SPAN_LSB = LINE_LSB + DEPTH_W;
  localparam logic [RDATA_W-1:0] ERR_VAL = RDATA_W'(ERR_RDATA);

  function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
    return (a >> SPAN_LSB) == '0;
  endfunction

  function automatic logic [DEPTH_W-1:0] lineOf(input logic [ADDR_W-1:0] a);
    return a[LINE_LSB +: DEPTH_W];
  endfunction

  function automatic logic [LANE_W-1:0] laneOf(input logic [ADDR_W-1:0] a);
    if (LANES > 1) return a[RD_LSB +: LANE_W];
    else           return '0;
  endfunction

  // ---------------------------------------------------------------- read side
  typedef enum logic [1:0] {
    R_IDLE,
`ifdef AXIL_SLV_MEM_OUTREG_EN
    R_PIPE,
`endif
    R_RESP
  } rdState_t;

  rdState_t             rdState, rdNext;
  logic                 arReadyInt, rValidInt, rdAddrFire;
  logic [WDATA_W-1:0]   memQ, rdLineQ;
  logic [LANE_W-1:0]    rdLane;
  logic                 rdInRange;
  logic [RDATA_W-1:0]   rdSel;

  always_ff @(posedge clock) begin
    if (reset) rdState <= R_IDLE;
    else       rdState <= rdNext;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rdNext     = rdState;
    arReadyInt = 1'b0;
    rValidInt  = 1'b0;
    case (rdState)
      R_IDLE: begin
        arReadyInt = 1'b1;
`ifdef AXIL_SLV_MEM_OUTREG_EN
        if (bus.readAddr_valid) rdNext = R_PIPE;
`else
        if (bus.readAddr_valid) rdNext = R_RESP;
`endif
      end
`ifdef AXIL_SLV_MEM_OUTREG_EN
      R_PIPE: rdNext = R_RESP;
`endif
      R_RESP: begin
        rValidInt = 1'b1;
        if (bus.readData_ready) rdNext = R_IDLE;
      end
      default: rdNext = R_IDLE;
    endcase
  end

  assign rdAddrFire = arReadyInt & bus.readAddr_valid;

  // Lane and range are only sampled at acceptance so the response stays stable.
  always_ff @(posedge clock) begin
    if (rdAddrFire) begin
      rdLane    <= laneOf(bus.readAddr_addr);
      rdInRange <= addrInRange(bus.readAddr_addr);
    end
  end

  // ---------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wrState_t;

  wrState_t             wrState, wrNext;
  logic                 awReadyInt, wReadyInt, bValidInt;
  logic                 awFire, wFire, awHeld, wHeld;
  logic [ADDR_W-1:0]    wrAddr;
  logic [WDATA_W-1:0]   wrData;
  logic [STRB_W-1:0]    wrStrb;
  logic                 wrInRange, wrCommit;
  logic [DEPTH_W-1:0]   wrLine;

  always_ff @(posedge clock) begin
    if (reset) wrState <= W_IDLE;
    else       wrState <= wrNext;
  end

  always_comb begin
    wrNext     = wrState;
    awReadyInt = 1'b0;
    wReadyInt  = 1'b0;
    bValidInt  = 1'b0;
    awFire     = 1'b0;
    wFire      = 1'b0;
    case (wrState)
      W_IDLE: begin
        awReadyInt = !awHeld;
        wReadyInt  = !wHeld;
        awFire     = awReadyInt & bus.writeAddr_valid;
        wFire      = wReadyInt & bus.writeData_valid;
        if ((awHeld || awFire) && (wHeld || wFire)) wrNext = W_COMMIT;
      end
      W_COMMIT: wrNext = W_RESP;
      W_RESP: begin
        bValidInt = 1'b1;
        if (bus.writeResp_ready) wrNext = W_IDLE;
      end
      default: wrNext = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      awHeld <= 1'b0;
      wHeld  <= 1'b0;
    end else if (wrState == W_IDLE && wrNext == W_COMMIT) begin
      awHeld <= 1'b0;
      wHeld  <= 1'b0;
    end else begin
      if (awFire) awHeld <= 1'b1;
      if (wFire)  wHeld  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (awFire) wrAddr <= bus.writeAddr_addr;
    if (wFire) begin
      wrData <= bus.writeData_data;
      wrStrb <= bus.writeData_strb;
    end
  end

  assign wrInRange = addrInRange(wrAddr);
  assign wrLine    = lineOf(wrAddr);
  assign wrCommit  = (wrState == W_COMMIT) && wrInRange && !reset;

  // ---------------------------------------------------------------- memory
  logic [WDATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; contents survive reset and it maps to RAM.
  // Read and write on the same edge see the old line (read-before-write).
  always_ff @(posedge clock) begin
    if (rdAddrFire) memQ <= mem[lineOf(bus.readAddr_addr)];
    if (wrCommit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wrStrb[b]) mem[wrLine][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

`ifdef AXIL_SLV_MEM_OUTREG_EN
  always_ff @(posedge clock) begin
    if (rdState == R_PIPE) rdLineQ <= memQ;
  end
`else
  assign rdLineQ = memQ;
`endif

  assign rdSel = rdLineQ[int'(rdLane)*RDATA_W +: RDATA_W];

  // ---------------------------------------------------------------- outputs
  // Outputs are masked by reset so they read zero during the reset cycles.
  logic rValidOut, bValidOut;
  assign rValidOut           = rValidInt & ~reset;
  assign bValidOut           = bValidInt & ~reset;
  assign bus.readAddr_ready  = arReadyInt & ~reset;
  assign bus.readData_valid  = rValidOut;
  assign bus.readData_data   = rValidOut ? (rdInRange ? rdSel : ERR_VAL) : '0;
  assign bus.writeAddr_ready = awReadyInt & ~reset;
  assign bus.writeData_ready = wReadyInt & ~reset;
  assign bus.writeResp_valid = bValidOut;
  assign bus.writeResp_msg   = bValidOut ? (wrInRange ? 32'd0 : 32'd2) : 32'd0;

endmodule

// File: tb/tb_axilite4_slave_mem.sv
// Directed, table-driven bench for axilite4_slave_mem: vector table plus
// hand sequences for ordering, read-before-write, backpressure and reset.
module tb_axilite4_slave_mem;

`ifdef AXIL_SLV_MEM_OUTREG_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axilite4_slave_mem_if #(.ADDR_W(32), .RDATA_W(32), .WDATA_W(128)) bus();

  axilite4_slave_mem #(
    .ADDR_W(32), .RDATA_W(32), .WDATA_W(128), .DEPTH(256), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic         isWrite;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic [31:0]  exp;   // write: response msg, read: data
  } vec_t;

  vec_t vecs[20];
  int   nVec = 0;
  int   nErr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All helpers are entered and left on a falling edge.
  task automatic issueRead(input logic [31:0] addr);
    int n = 0;
    bus.readAddr_addr  = addr;
    bus.readAddr_valid = 1'b1;
    while (!bus.readAddr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.readAddr_ready) check("rdAddrTimeout", 128'(0), 128'(1));
    @(negedge clock);
    bus.readAddr_valid = 1'b0;
  endtask

  task automatic waitRead(output logic [31:0] data, output int lat);
    lat = 1;
    while (!bus.readData_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (!bus.readData_valid) check("rdDataTimeout", 128'(0), 128'(1));
    data = bus.readData_data;
  endtask

  task automatic ackRead();
    bus.readData_ready = 1'b1;
    @(negedge clock);
    bus.readData_ready = 1'b0;
    check("rdReadyAfter", 128'(bus.readAddr_ready), 128'(1));
  endtask

  task automatic doRead(input logic [31:0] addr, output logic [31:0] data);
    int lat;
    issueRead(addr);
    waitRead(data, lat);
    check($sformatf("rdLat@%0h", addr), 128'(lat), 128'(EXP_LAT));
    ackRead();
  endtask

  // mode 0: address and data together, 1: data first, 2: address first
  task automatic issueWrite(input logic [31:0] addr, input logic [127:0] data,
                            input logic [15:0] strb, input int mode);
    check("wrReadyIdle", 128'({bus.writeAddr_ready, bus.writeData_ready}), 128'(2'b11));
    bus.writeAddr_addr = addr;
    bus.writeData_data = data;
    bus.writeData_strb = strb;
    case (mode)
      1: begin
        bus.writeData_valid = 1'b1;
        @(negedge clock);
        check("wrDataFirstReady", 128'({bus.writeAddr_ready, bus.writeData_ready}), 128'(2'b10));
        bus.writeData_valid = 1'b0;
        bus.writeAddr_valid = 1'b1;
      end
      2: begin
        bus.writeAddr_valid = 1'b1;
        @(negedge clock);
        check("wrAddrFirstReady", 128'({bus.writeAddr_ready, bus.writeData_ready}), 128'(2'b01));
        bus.writeAddr_valid = 1'b0;
        bus.writeData_valid = 1'b1;
      end
      default: begin
        bus.writeAddr_valid = 1'b1;
        bus.writeData_valid = 1'b1;
      end
    endcase
    @(negedge clock);
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
  endtask

  task automatic waitResp(output logic [31:0] msg);
    int n = 0;
    while (!bus.writeResp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.writeResp_valid) check("wrRespTimeout", 128'(0), 128'(1));
    msg = bus.writeResp_msg;
  endtask

  task automatic ackResp();
    bus.writeResp_ready = 1'b1;
    @(negedge clock);
    bus.writeResp_ready = 1'b0;
    check("wrOneResp", 128'(bus.writeResp_valid), 128'(0));
    check("wrReadyAfter", 128'({bus.writeAddr_ready, bus.writeData_ready}), 128'(2'b11));
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [127:0] data,
                         input logic [15:0] strb, input int mode, input logic [31:0] expMsg);
    logic [31:0] msg;
    issueWrite(addr, data, strb, mode);
    waitResp(msg);
    check($sformatf("wrMsg@%0h", addr), 128'(msg), 128'(expMsg));
    ackResp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, msg;
    int          lat;

    bus.readAddr_addr   = '0;
    bus.readAddr_valid  = 1'b0;
    bus.readData_ready  = 1'b0;
    bus.writeAddr_addr  = '0;
    bus.writeAddr_valid = 1'b0;
    bus.writeData_data  = '0;
    bus.writeData_strb  = '0;
    bus.writeData_valid = 1'b0;
    bus.writeResp_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h010, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, 32'd0};
    vecs[1]  = '{1'b0, 32'h010, 128'h0, 16'h0, 32'hCCDDEEFF};
    vecs[2]  = '{1'b0, 32'h014, 128'h0, 16'h0, 32'h8899AABB};
    vecs[3]  = '{1'b0, 32'h018, 128'h0, 16'h0, 32'h44556677};
    vecs[4]  = '{1'b0, 32'h01C, 128'h0, 16'h0, 32'h00112233};
    vecs[5]  = '{1'b0, 32'h013, 128'h0, 16'h0, 32'hCCDDEEFF};
    vecs[6]  = '{1'b1, 32'h020, {128{1'b1}}, 16'hFFFF, 32'd0};
    vecs[7]  = '{1'b1, 32'h020, 128'h0, 16'h000F, 32'd0};
    vecs[8]  = '{1'b0, 32'h020, 128'h0, 16'h0, 32'h00000000};
    vecs[9]  = '{1'b0, 32'h024, 128'h0, 16'h0, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 32'h000, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 32'd0};
    vecs[11] = '{1'b1, 32'h1000, 128'h0, 16'hFFFF, 32'd2};
    vecs[12] = '{1'b0, 32'h000, 128'h0, 16'h0, 32'h03020100};
    vecs[13] = '{1'b0, 32'h00C, 128'h0, 16'h0, 32'h0F0E0D0C};
    vecs[14] = '{1'b0, 32'h1000, 128'h0, 16'h0, 32'hDEADBEEF};
    vecs[15] = '{1'b1, 32'hFF0, 128'hCAFEF00D000000000000000012345678, 16'hFFFF, 32'd0};
    vecs[16] = '{1'b0, 32'hFFC, 128'h0, 16'h0, 32'hCAFEF00D};
    vecs[17] = '{1'b0, 32'hFF0, 128'h0, 16'h0, 32'h12345678};
    vecs[18] = '{1'b1, 32'h010, 128'h0, 16'h0000, 32'd0};
    vecs[19] = '{1'b0, 32'h010, 128'h0, 16'h0, 32'hCCDDEEFF};

    // Reset state
    repeat (3) @(negedge clock);
    check("rstCtrl", 128'({bus.readAddr_ready, bus.readData_valid, bus.writeAddr_ready,
                          bus.writeData_ready, bus.writeResp_valid}), 128'(0));
    check("rstRdata", 128'(bus.readData_data), 128'(0));
    check("rstMsg", 128'(bus.writeResp_msg), 128'(0));
    reset = 1'b0;
    @(negedge clock);
    check("postRstReady", 128'({bus.readAddr_ready, bus.writeAddr_ready, bus.writeData_ready}),
          128'(3'b111));

    // Vector table
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].isWrite) begin
        issueWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3);
        waitResp(msg);
        check($sformatf("vec%0d.msg", i), 128'(msg), 128'(vecs[i].exp));
        ackResp();
      end else begin
        doRead(vecs[i].addr, rd);
        check($sformatf("vec%0d.data", i), 128'(rd), 128'(vecs[i].exp));
      end
    end

    // Read on the commit edge of a write to the same line returns the old data
    doWrite(32'h040, 128'h44444444333333332222222211111111, 16'hFFFF, 0, 32'd0);
    bus.writeAddr_addr  = 32'h040;
    bus.writeData_data  = 128'h0000000000000000BBBBBBBBAAAAAAAA;
    bus.writeData_strb  = 16'hFFFF;
    bus.writeAddr_valid = 1'b1;
    bus.writeData_valid = 1'b1;
    @(negedge clock);
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    bus.readAddr_addr   = 32'h040;
    bus.readAddr_valid  = 1'b1;
    check("collArReady", 128'(bus.readAddr_ready), 128'(1));
    @(negedge clock);
    bus.readAddr_valid = 1'b0;
    waitRead(rd, lat);
    check("collOldData", 128'(rd), 128'(32'h11111111));
    check("collLat", 128'(lat), 128'(EXP_LAT));
    ackRead();
    waitResp(msg);
    check("collMsg", 128'(msg), 128'(0));
    ackResp();
    doRead(32'h040, rd);
    check("collNewData", 128'(rd), 128'(32'hAAAAAAAA));

    // Read backpressure with a pending address that must wait
    issueRead(32'h014);
    waitRead(rd, lat);
    bus.readAddr_addr  = 32'h018;
    bus.readAddr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bpRdValid", 128'(bus.readData_valid), 128'(1));
      check("bpRdData", 128'(bus.readData_data), 128'(32'h8899AABB));
      check("bpArReady", 128'(bus.readAddr_ready), 128'(0));
      @(negedge clock);
    end
    bus.readData_ready = 1'b1;
    @(negedge clock);
    bus.readData_ready = 1'b0;
    check("bpArReadyAfter", 128'(bus.readAddr_ready), 128'(1));
    @(negedge clock);
    bus.readAddr_valid = 1'b0;
    waitRead(rd, lat);
    check("bpNextData", 128'(rd), 128'(32'h44556677));
    check("bpNextLat", 128'(lat), 128'(EXP_LAT));
    ackRead();

    // Write backpressure; a second write offered meanwhile must not be taken
    issueWrite(32'h050, 128'h00000000000000000000000055555555, 16'hFFFF, 0);
    waitResp(msg);
    bus.writeAddr_addr  = 32'h050;
    bus.writeData_data  = 128'h0;
    bus.writeAddr_valid = 1'b1;
    bus.writeData_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bpWrValid", 128'(bus.writeResp_valid), 128'(1));
      check("bpWrMsg", 128'(bus.writeResp_msg), 128'(0));
      check("bpWrReadies", 128'({bus.writeAddr_ready, bus.writeData_ready}), 128'(0));
      @(negedge clock);
    end
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    ackResp();
    doRead(32'h050, rd);
    check("bpWrData", 128'(rd), 128'(32'h55555555));

    // Reset while both FSMs hold a response
    issueWrite(32'h030, 128'h000000000000000000000000600DF00D, 16'hFFFF, 0);
    waitResp(msg);
    issueRead(32'h034);
    waitRead(rd, lat);
    check("preRstValids", 128'({bus.readData_valid, bus.writeResp_valid}), 128'(2'b11));
    reset = 1'b1;
    @(negedge clock);
    check("midRstValids", 128'({bus.readData_valid, bus.writeResp_valid}), 128'(0));
    check("midRstReadies", 128'({bus.readAddr_ready, bus.writeAddr_ready, bus.writeData_ready}),
          128'(0));
    reset = 1'b0;
    @(negedge clock);
    check("rstReadiesBack", 128'({bus.readAddr_ready, bus.writeAddr_ready, bus.writeData_ready}),
          128'(3'b111));
    for (int k = 0; k < 3; k++) begin
      check("noRespAfterRst", 128'({bus.readData_valid, bus.writeResp_valid}), 128'(0));
      @(negedge clock);
    end
    doRead(32'h030, rd);
    check("rstMemKept", 128'(rd), 128'(32'h600DF00D));
    doRead(32'h010, rd);
    check("rstMemKeptOld", 128'(rd), 128'(32'hCCDDEEFF));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
